// File: rtl/localbus_pkg.sv
// Shared types and constants for the local-bus frame decoder.
package localbus_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_ISSUE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_HDR  = 2'd1,
        ERR_SEQ  = 2'd2,
        ERR_OVR  = 2'd3
    } err_t;

    // Header (unit 0) field positions
    localparam int unsigned HDR_SYNC_LSB = 24;
    localparam int unsigned HDR_CMD_LSB  = 16;
    localparam int unsigned HDR_ADDR_LSB = 8;
    localparam int unsigned HDR_N_LSB    = 0;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] CMD_DEFAULT  = 8'h01;

    // A header is accepted only with matching sync/command and 1..3 data units
    function automatic logic hdr_ok(input logic [31:0] hdr,
                                    input logic [7:0]  sync,
                                    input logic [7:0]  cmd);
        logic [7:0] n;
        n = hdr[HDR_N_LSB +: 8];
        return (hdr[HDR_SYNC_LSB +: 8] == sync) &&
               (hdr[HDR_CMD_LSB +: 8] == cmd) &&
               (n != 8'd0) && (n <= 8'd3);
    endfunction

endpackage

// File: rtl/localbus_unit_arbiter.sv
// Folds the four per-unit finish/data pairs into one stream, lowest index first.
module localbus_unit_arbiter #(
    parameter int unsigned UNIT_BIT_NUM = 32
) (
    input  logic [3:0]              finish,
    input  logic [UNIT_BIT_NUM-1:0] data_0,
    input  logic [UNIT_BIT_NUM-1:0] data_1,
    input  logic [UNIT_BIT_NUM-1:0] data_2,
    input  logic [UNIT_BIT_NUM-1:0] data_3,
    output logic                    hit,
    output logic [1:0]              idx,
    output logic [UNIT_BIT_NUM-1:0] data,
    output logic                    multi
);

    // Priority select of the lowest pending unit; flag cycles with more than one pulse
    always_comb begin
        hit   = 1'b0;
        idx   = 2'd0;
        data  = '0;
        multi = ((finish & (finish - 4'd1)) != 4'd0);
        if (finish[0]) begin
            hit  = 1'b1;
            idx  = 2'd0;
            data = data_0;
        end else if (finish[1]) begin
            hit  = 1'b1;
            idx  = 2'd1;
            data = data_1;
        end else if (finish[2]) begin
            hit  = 1'b1;
            idx  = 2'd2;
            data = data_2;
        end else if (finish[3]) begin
            hit  = 1'b1;
            idx  = 2'd3;
            data = data_3;
        end
    end

endmodule

// File: rtl/localbus_frame_decoder.sv
// Validates a local-bus header, collects its data units and replays them
// as register writes on a valid/ready port.
module localbus_frame_decoder
    import localbus_pkg::*;
#(
    parameter int unsigned UNIT_BIT_NUM = 32,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_DEFAULT,
    parameter logic [7:0]  CMD_WRITE    = CMD_DEFAULT,
    parameter int unsigned TIMEOUT_CYC  = 1024
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    LB_FINISH_0_I,
    input  logic                    LB_FINISH_1_I,
    input  logic                    LB_FINISH_2_I,
    input  logic                    LB_FINISH_3_I,
    input  logic [UNIT_BIT_NUM-1:0] LB_DATA_0_I,
    input  logic [UNIT_BIT_NUM-1:0] LB_DATA_1_I,
    input  logic [UNIT_BIT_NUM-1:0] LB_DATA_2_I,
    input  logic [UNIT_BIT_NUM-1:0] LB_DATA_3_I,
    output logic                    WR_VALID_O,
    input  logic                    WR_READY_I,
    output logic [7:0]              WR_ADDR_O,
    output logic [31:0]             WR_DATA_O,
    output logic                    BUSY_O,
    output logic                    ERR_PULSE_O,
    output logic [1:0]              ERR_CODE_O,
    output logic [15:0]             FRAME_CNT_O
);

    logic                    arb_hit;
    logic [1:0]              arb_idx;
    logic [UNIT_BIT_NUM-1:0] arb_data;
    logic                    arb_multi;

    state_t      state;
    err_t        err_code;
    logic        err_pulse;
    logic [7:0]  base_addr;
    logic [1:0]  num;
    logic [1:0]  exp_idx;
    logic        complete;
    logic [15:0] tmo_cnt;
    logic [31:0] slot [3];
    logic        wr_valid;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_idx;
    logic [15:0] frame_cnt;

    localbus_unit_arbiter #(
        .UNIT_BIT_NUM(UNIT_BIT_NUM)
    ) u_arb (
        .finish({LB_FINISH_3_I, LB_FINISH_2_I, LB_FINISH_1_I, LB_FINISH_0_I}),
        .data_0(LB_DATA_0_I),
        .data_1(LB_DATA_1_I),
        .data_2(LB_DATA_2_I),
        .data_3(LB_DATA_3_I),
        .hit   (arb_hit),
        .idx   (arb_idx),
        .data  (arb_data),
        .multi (arb_multi)
    );

    // Frame FSM: header check, in-order collection, write replay, error/status tracking
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state     <= S_IDLE;
            err_code  <= ERR_NONE;
            err_pulse <= 1'b0;
            base_addr <= '0;
            num       <= '0;
            exp_idx   <= '0;
            complete  <= 1'b0;
            tmo_cnt   <= '0;
            for (int unsigned i = 0; i < 3; i++) slot[i] <= '0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_idx    <= '0;
            frame_cnt <= '0;
        end else begin
            err_pulse <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (arb_hit && arb_idx == 2'd0) begin
                        if (arb_multi) begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_SEQ;
                        end else if (hdr_ok(arb_data[31:0], SYNC_BYTE, CMD_WRITE)) begin
                            base_addr <= arb_data[HDR_ADDR_LSB +: 8];
                            num       <= arb_data[HDR_N_LSB +: 2];
                            exp_idx   <= 2'd1;
                            complete  <= 1'b0;
                            tmo_cnt   <= '0;
                            state     <= S_COLLECT;
                        end else begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_HDR;
                        end
                    end
                end
                S_COLLECT: begin
                    // The cycle after the last unit is a hand-over cycle into
                    // ISSUE; the frame is already whole, so pulses here overrun.
                    if (complete) begin
                        complete <= 1'b0;
                        wr_valid <= 1'b1;
                        wr_addr  <= base_addr;
                        wr_data  <= slot[0];
                        wr_idx   <= 2'd0;
                        state    <= S_ISSUE;
                        if (arb_hit) begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_OVR;
                        end
                    end else if (arb_hit) begin
                        if (arb_multi || arb_idx != exp_idx) begin
                            err_pulse <= 1'b1;
                            err_code  <= ERR_SEQ;
                            state     <= S_IDLE;
                        end else begin
                            slot[exp_idx - 2'd1] <= arb_data[31:0];
                            if (exp_idx == num) complete <= 1'b1;
                            else                exp_idx  <= exp_idx + 2'd1;
                            tmo_cnt <= tmo_cnt + 16'd1;
                        end
                    end else if (tmo_cnt == 16'(TIMEOUT_CYC - 1)) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_SEQ;
                        state     <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_ISSUE: begin
                    if (arb_hit) begin
                        err_pulse <= 1'b1;
                        err_code  <= ERR_OVR;
                    end
                    if (wr_valid && WR_READY_I) begin
                        if (wr_idx == num - 2'd1) begin
                            wr_valid  <= 1'b0;
                            frame_cnt <= frame_cnt + 16'd1;
                            state     <= S_IDLE;
                        end else begin
                            wr_idx  <= wr_idx + 2'd1;
                            wr_addr <= wr_addr + 8'd1;
                            wr_data <= slot[wr_idx + 2'd1];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign WR_VALID_O  = wr_valid;
    assign WR_ADDR_O   = wr_addr;
    assign WR_DATA_O   = wr_data;
    assign BUSY_O      = (state != S_IDLE);
    assign ERR_PULSE_O = err_pulse;
    assign ERR_CODE_O  = err_code;
    assign FRAME_CNT_O = frame_cnt;

endmodule

// File: tb/tb_localbus_frame_decoder.sv
// Directed bench for localbus_frame_decoder.
module tb_localbus_frame_decoder;

    localparam int unsigned TMO = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fin;
    logic [31:0] d0, d1, d2, d3;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy, err_pulse;
    logic [1:0]  err_code;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [39:0] wq[$];
    int          wc[$];

    always #5 clk = ~clk;

    localbus_frame_decoder #(
        .UNIT_BIT_NUM(32),
        .SYNC_BYTE   (8'hA5),
        .CMD_WRITE   (8'h01),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .CLK_I        (clk),
        .RST_I        (rst),
        .LB_FINISH_0_I(fin[0]),
        .LB_FINISH_1_I(fin[1]),
        .LB_FINISH_2_I(fin[2]),
        .LB_FINISH_3_I(fin[3]),
        .LB_DATA_0_I  (d0),
        .LB_DATA_1_I  (d1),
        .LB_DATA_2_I  (d2),
        .LB_DATA_3_I  (d3),
        .WR_VALID_O   (wr_valid),
        .WR_READY_I   (wr_ready),
        .WR_ADDR_O    (wr_addr),
        .WR_DATA_O    (wr_data),
        .BUSY_O       (busy),
        .ERR_PULSE_O  (err_pulse),
        .ERR_CODE_O   (err_code),
        .FRAME_CNT_O  (frame_cnt)
    );

    // Record every accepted write with the cycle it was accepted in
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && wr_valid && wr_ready) begin
            wq.push_back({wr_addr, wr_data});
            wc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int k, input logic [31:0] v);
        fin = 4'b0001 << k;
        case (k)
            0: d0 = v;
            1: d1 = v;
            2: d2 = v;
            default: d3 = v;
        endcase
        tick();
        fin = 4'b0000;
    endtask

    task automatic check_write(input string tag, input int i, input logic [7:0] a, input logic [31:0] d);
        if (wq.size() > i) chk(tag, wq[i], {a, d});
        else               chk({tag, "_missing"}, 40'd0, {a, d});
    endtask

    initial begin
        rst = 1'b1; fin = '0; d0 = '0; d1 = '0; d2 = '0; d3 = '0; wr_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_outs", {wr_valid, busy, err_pulse, err_code, wr_addr, 32'(frame_cnt)},
            {1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 32'd0});
        chk("rst_data", {8'd0, wr_data}, 40'd0);

        // Basic write, READY high
        wr_ready = 1'b1;
        pulse(0, 32'hA5011003);
        chk("basic_busy", busy, 1);
        pulse(1, 32'h11111111);
        pulse(2, 32'h22222222);
        pulse(3, 32'h33333333);
        chk("basic_lat1", wr_valid, 0);
        tick();
        chk("basic_lat2", {wr_valid, wr_addr, wr_data}, {1'b1, 8'h10, 32'h11111111});
        repeat (4) tick();
        chk("basic_n", wq.size(), 3);
        check_write("basic_w0", 0, 8'h10, 32'h11111111);
        check_write("basic_w1", 1, 8'h11, 32'h22222222);
        check_write("basic_w2", 2, 8'h12, 32'h33333333);
        if (wc.size() == 3) chk("basic_b2b", {wc[1] - wc[0], wc[2] - wc[1]}, {32'd1, 32'd1});
        else                chk("basic_b2b_n", wc.size(), 3);
        chk("basic_cnt", {busy, err_code, 32'(frame_cnt)}, {1'b0, 2'd0, 32'd1});
        wq.delete(); wc.delete();

        // Backpressure with address wrap
        wr_ready = 1'b0;
        pulse(0, 32'hA501FF02);
        pulse(1, 32'hAAAA5555);
        pulse(2, 32'h5555AAAA);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold", {wr_valid, wr_addr, wr_data}, {1'b1, 8'hFF, 32'hAAAA5555});
            tick();
        end
        wr_ready = 1'b1;
        tick();
        chk("bp_wrap", {wr_valid, wr_addr, wr_data}, {1'b1, 8'h00, 32'h5555AAAA});
        tick();
        chk("bp_done", {wr_valid, busy, 32'(frame_cnt)}, {1'b0, 1'b0, 32'd2});
        chk("bp_n", wq.size(), 2);
        check_write("bp_w0", 0, 8'hFF, 32'hAAAA5555);
        check_write("bp_w1", 1, 8'h00, 32'h5555AAAA);
        wq.delete(); wc.delete();

        // Bad headers: sync, command, count
        pulse(0, 32'h5A010001);
        chk("hdr_sync", {err_pulse, err_code, busy}, {1'b1, 2'd1, 1'b0});
        tick();
        chk("hdr_pulse_end", err_pulse, 0);
        pulse(0, 32'hA5020001);
        chk("hdr_cmd", {err_pulse, err_code, busy}, {1'b1, 2'd1, 1'b0});
        tick();
        pulse(0, 32'hA5010004);
        chk("hdr_n", {err_pulse, err_code, busy}, {1'b1, 2'd1, 1'b0});
        tick(); tick();
        chk("hdr_nowr", {wq.size(), 31'(wr_valid)}, {32'd0, 31'd0});

        // Sequence error: unit 2 before unit 1
        pulse(0, 32'hA5010002);
        chk("seq_busy", busy, 1);
        pulse(2, 32'h12345678);
        chk("seq_err", {err_pulse, err_code, busy}, {1'b1, 2'd2, 1'b0});
        tick();

        // Timeout: header with no data
        pulse(0, 32'hA5010001);
        begin
            int n;
            n = 0;
            while (!err_pulse && n < 2 * TMO) begin
                tick();
                n++;
            end
            chk("tmo_err", {err_pulse, err_code, busy}, {1'b1, 2'd2, 1'b0});
            chk("tmo_cycles", n, TMO);
        end
        tick();

        // Overrun: new header while a frame is being issued
        wr_ready = 1'b0;
        pulse(0, 32'hA5012002);
        pulse(1, 32'h01020304);
        pulse(2, 32'h05060708);
        tick();
        chk("ovr_issue", {wr_valid, wr_addr}, {1'b1, 8'h20});
        pulse(0, 32'hA5013001);
        chk("ovr_err", {err_pulse, err_code, wr_valid, wr_addr, wr_data},
            {1'b1, 2'd3, 1'b1, 8'h20, 32'h01020304});
        wr_ready = 1'b1;
        repeat (4) tick();
        chk("ovr_n", wq.size(), 2);
        check_write("ovr_w0", 0, 8'h20, 32'h01020304);
        check_write("ovr_w1", 1, 8'h21, 32'h05060708);
        chk("ovr_cnt", {busy, 32'(frame_cnt)}, {1'b0, 32'd3});
        wq.delete(); wc.delete();

        // Reset while a write is pending
        wr_ready = 1'b0;
        pulse(0, 32'hA5014001);
        pulse(1, 32'hDEADBEEF);
        tick();
        chk("mrst_pre", {wr_valid, wr_addr, wr_data}, {1'b1, 8'h40, 32'hDEADBEEF});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_post", {wr_valid, busy, err_code, 32'(frame_cnt)}, {1'b0, 1'b0, 2'd0, 32'd0});
        wr_ready = 1'b1;
        pulse(0, 32'hA5015002);
        pulse(1, 32'hCAFE0001);
        pulse(2, 32'hCAFE0002);
        repeat (5) tick();
        chk("mrst_n", wq.size(), 2);
        check_write("mrst_w0", 0, 8'h50, 32'hCAFE0001);
        check_write("mrst_w1", 1, 8'h51, 32'hCAFE0002);
        chk("mrst_cnt", {busy, err_code, 32'(frame_cnt)}, {1'b0, 2'd0, 32'd1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
